// File: rtl/lg_arbiter_ctrl.sv
// Two-requester front end for a shared logic-gate unit: grant, latch operands, evaluate, return tagged result.
// Define LG_FIXED_PRIO_EN to make requester 0 always win a simultaneous request.
module lg_arbiter_ctrl #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             res_id,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state;
    logic             last_winner;
    logic             pick1;
    logic [2:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             id_p0;

    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = ~(a & b);
            3'd2:    r = a | b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~a;
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return (op == 3'd7);
    endfunction

    // Winner selection; only meaningful when at least one request is up.
    always_comb begin
`ifdef LG_FIXED_PRIO_EN
        pick1 = req1 && !req0;
`else
        if (req0 && req1) begin
            pick1 = ~last_winner;
        end else begin
            pick1 = req1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            busy        <= 1'b0;
            res         <= '0;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                // Stage p0: sample requests and capture the winner's operation.
                IDLE: begin
                    res_valid <= 1'b0;
                    if (req0 || req1) begin
                        id_p0       <= pick1;
                        op_p0       <= pick1 ? op1 : op0;
                        a_p0        <= pick1 ? a1 : a0;
                        b_p0        <= pick1 ? b1 : b0;
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        busy        <= 1'b1;
                        last_winner <= pick1;
                        state       <= EXEC;
                    end else begin
                        gnt0 <= 1'b0;
                        gnt1 <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                // Stage p1: evaluate the latched operation and publish it.
                EXEC: begin
                    res       <= gate_eval(op_p0, a_p0, b_p0);
                    err       <= is_reserved(op_p0);
                    res_id    <= id_p0;
                    res_valid <= 1'b1;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lg_arbiter_ctrl.sv
// Directed bench for lg_arbiter_ctrl: expected results queued at issue time, popped when res_valid fires.
module tb_lg_arbiter_ctrl;

    localparam int WIDTH = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [2:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, busy, res_valid, res_id, err;
    logic [WIDTH-1:0] res;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             id;
        logic             err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Truth tables for patterns (A,B) = (0,0),(1,0),(0,1),(1,1), first pattern in the MSB.
    logic [3:0] tt [0:6];

    lg_arbiter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .res(res), .res_valid(res_valid), .res_id(res_id), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] r, input logic id, input logic e);
        exp_t x;
        x.res = r;
        x.id  = id;
        x.err = e;
        sbq.push_back(x);
    endtask

    // Wait (bounded) for res_valid and compare against the oldest queued expectation.
    task automatic collect(input string tag);
        int   n;
        exp_t x;
        n = 0;
        while (!res_valid && n < 4) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, int'(res_valid), 1);
        if (res_valid) begin
            if (sbq.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 0, 1);
            end else begin
                x = sbq.pop_front();
                chk({tag, "_res"}, int'(res), int'(x.res));
                chk({tag, "_id"}, int'(res_id), int'(x.id));
                chk({tag, "_err"}, int'(err), int'(x.err));
            end
        end
    endtask

    task automatic do_op(input string tag, input logic r, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] er, input logic ee);
        push(er, r, ee);
        if (r) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        step();
        chk({tag, "_gnt0"}, int'(gnt0), int'(!r));
        chk({tag, "_gnt1"}, int'(gnt1), int'(r));
        chk({tag, "_busy"}, int'(busy), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        collect(tag);
        chk({tag, "_gnt_clr"}, int'(gnt0 | gnt1), 0);
        chk({tag, "_busy_clr"}, int'(busy), 0);
        step();
        chk({tag, "_pulse"}, int'(res_valid), 0);
    endtask

    initial begin
        tt[0] = 4'b0001; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b1000;
        tt[4] = 4'b1010; tt[5] = 4'b0110; tt[6] = 4'b1001;

        rst = 1'b1;
        req0 = 1'b0; op0 = 3'd0; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = 3'd0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_id", int'(res_id), 0);
        chk("rst_err", int'(err), 0);

        do_op("first_and", 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int op = 0; op < 7; op++) begin
            for (int p = 0; p < 4; p++) begin
                do_op($sformatf("tt_op%0d_p%0d", op, p), 1'b1, 3'(op),
                      1'(p % 2), 1'(p / 2), tt[op][3-p], 1'b0);
            end
        end

        // Both requesters held: OR (=1) from 0, XOR (=0) from 1.
        for (int k = 0; k < 4; k++) begin
`ifdef LG_FIXED_PRIO_EN
            push(1'b1, 1'b0, 1'b0);
`else
            push((k % 2 == 0) ? 1'b1 : 1'b0, 1'(k % 2), 1'b0);
`endif
        end
        req0 = 1'b1; op0 = 3'd2; a0 = 1'b1; b0 = 1'b1;
        req1 = 1'b1; op1 = 3'd5; a1 = 1'b1; b1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef LG_FIXED_PRIO_EN
            chk($sformatf("both_k%0d_gnt0", k), int'(gnt0), 1);
            chk($sformatf("both_k%0d_gnt1", k), int'(gnt1), 0);
`else
            chk($sformatf("both_k%0d_gnt0", k), int'(gnt0), int'(k % 2 == 0));
            chk($sformatf("both_k%0d_gnt1", k), int'(gnt1), int'(k % 2 == 1));
`endif
            step();
            collect($sformatf("both_k%0d", k));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("both_idle_valid", int'(res_valid), 0);

        do_op("reserved", 1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("reserved_err_hold", int'(err), 1);
        do_op("err_clear", 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset while requester 1's operation is in EXEC.
        req1 = 1'b1; op1 = 3'd2; a1 = 1'b1; b1 = 1'b1;
        step();
        chk("midrst_gnt1", int'(gnt1), 1);
        req1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", int'(res_valid), 0);
        chk("midrst_gnt", int'(gnt0 | gnt1), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_res", int'(res), 0);
        chk("midrst_id", int'(res_id), 0);
        chk("midrst_err", int'(err), 0);
        step();
        chk("midrst_no_late_valid", int'(res_valid), 0);
        do_op("after_rst", 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Operand A changes while gnt0 is high; the latched copy must be used.
        push(1'b1, 1'b0, 1'b0);
        req0 = 1'b1; op0 = 3'd0; a0 = 1'b1; b0 = 1'b1;
        step();
        chk("latch_gnt0", int'(gnt0), 1);
        a0 = 1'b0;
        req0 = 1'b0;
        step();
        collect("latch");
        step();

        chk("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lg_arbiter_ctrl.md
Name: lg_arbiter_ctrl

Overview:
Shares one logic-gate evaluation unit between two requesters. The unit implements AND/NAND/OR/NOR/NOT/XOR/XNOR.
- Arbitrates between the requesters.
- Latches the winner's operands and opcode.
- Evaluates the selected gate function and returns a registered result tagged with the requester ID.
- Sits between operand-producing blocks and the logic-gate datapath, sequencing one operation every 2 cycles.

Parameters:
WIDTH, 1, operand/result width in bits (bitwise gate operation).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 request
op0  input  3  requester 0 opcode
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
req1  input  1  requester 1 request
op1  input  3  requester 1 opcode
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  grant pulse to requester 0
gnt1  output  1  grant pulse to requester 1
busy  output  1  high while an operation is in flight
res  output  WIDTH  registered result
res_valid  output  1  one-cycle pulse, res/res_id/err valid
res_id  output  1  requester that owns res (0 or 1)
err  output  1  reserved opcode flag, valid with res_valid

Behaviour:
- Clock and reset:
  - Single clock domain; clock port is clk; reset is synchronous, active-high, port rst.
  - Reset values: gnt0=0, gnt1=0, busy=0, res=0, res_valid=0, res_id=0, err=0, state=IDLE, last_winner=1 (so req0 wins the first tie).
- Opcode encoding:
  - 0 AND: A&B
  - 1 NAND: ~(A&B)
  - 2 OR: A|B
  - 3 NOR: ~(A|B)
  - 4 NOT: ~A (B ignored)
  - 5 XOR: A^B
  - 6 XNOR: ~(A^B)
  - 7 reserved: res=0, err=1
- FSM states: IDLE, EXEC.
- IDLE:
  - No req: stay in IDLE; all pulses low.
  - Any req: select winner, latch that requester's op/a/b into internal registers, set the corresponding gnt<=1 and busy<=1, go to EXEC.
- Arbitration (round-robin):
  - Single requester: it wins.
  - Both requesting: winner is the requester != last_winner.
  - last_winner is updated on every grant.
- EXEC:
  - Evaluate the latched op on the latched operands: res<=f(a,b), err<=(op==7), res_id<=winner, res_valid<=1.
  - gnt cleared, busy<=0, go to IDLE.
- Timing: req sampled high at edge E0 -> gnt high during cycle E0..E1 -> res_valid high during cycle E1..E2.
  - Latency req->res_valid: 2 cycles.
  - Throughput: 1 operation per 2 cycles.
- Handshake:
  - Requester holds req, op, a and b stable until it samples gnt=1.
  - At that same edge it deasserts req, or presents a new operation.
  - Operands may change after the grant edge; latched copies are used.
- res and res_id hold their values between res_valid pulses. err clears to 0 at the next res_valid for a non-reserved opcode.
- Requests arriving during EXEC are not sampled until the next IDLE cycle.
- gnt0 and gnt1 are never high together; each is high for exactly 1 cycle per grant.
- Reset mid-operation (rst high in EXEC): in-flight operation dropped, no res_valid, all outputs go to reset values on that edge.
- Reset has priority over all other events on the same edge.

Optional Feature:
LG_FIXED_PRIO_EN
- Defined: fixed priority, req0 always wins over req1. last_winner is still tracked but ignored.
- Not defined: round-robin as described above.

Test Plan:
- Reset, then req0=1, op0=0, a0=1, b0=1 -> gnt0 pulse at cycle 1; res_valid at cycle 2 with res=1, res_id=0, err=0.
- Truth-table sweep on requester 1, ops 0..6 with (A,B)=(0,0),(1,0),(0,1),(1,1):
  - Expected results: AND 0001, NAND 1110, OR 0111, NOR 1000, NOT 1010, XOR 0110, XNOR 1001, in the order listed.
  - Each result arrives with res_id=1.
- req0 and req1 held high continuously, op0=2, op1=5, all operands 1:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - res sequence 1,0,1,0 with res_id 0,1,0,1.
  - With LG_FIXED_PRIO_EN: only gnt0, always res_id=0.
- op0=7, a0=1, b0=1 -> res_valid with res=0, err=1. Next op0=0 -> err=0.
- Grant req1, then assert rst for 1 cycle during EXEC:
  - No res_valid; all outputs 0; busy=0.
  - Next req0 (single requester) is granted normally.
- Change a0 from 1 to 0 on the cycle gnt0 is high (op0=0, b0=1) -> res=1, confirming operands were latched at the grant edge.
